// File: rtl/operands_stage_n.sv
// Operand-fetch stage between decode and execute: it registers the decoded control, reads the register file with write-back bypass, and refreshes stalled operands from write-back.
// Optional rs3 fetch is enabled by defining OPERANDS_RS3_EN.
module operands_stage_n #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned CTRL_W = 20,
  parameter int unsigned SID_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES-1:0]        stall_i,
  input  logic [LANES-1:0]        flush_i,
  input  logic [LANES-1:0]        dec_valid_i,
  input  logic [LANES-1:0]        dec_rs1_valid_i,
  input  logic [LANES-1:0]        dec_rs2_valid_i,
  input  logic [LANES-1:0]        dec_rs3_valid_i,
  input  logic [LANES*AW-1:0]     dec_rs1_i,
  input  logic [LANES*AW-1:0]     dec_rs2_i,
  input  logic [LANES*AW-1:0]     dec_rs3_i,
  input  logic [LANES*AW-1:0]     dec_rd_i,
  input  logic [LANES*CTRL_W-1:0] dec_ctrl_i,
  input  logic [LANES*SID_W-1:0]  dec_sid_i,
  output logic [LANES-1:0]        op_valid_o,
  output logic [LANES-1:0]        op_rs1_valid_o,
  output logic [LANES-1:0]        op_rs2_valid_o,
  output logic [LANES-1:0]        op_rs3_valid_o,
  output logic [LANES*AW-1:0]     op_rs1_o,
  output logic [LANES*AW-1:0]     op_rs2_o,
  output logic [LANES*AW-1:0]     op_rs3_o,
  output logic [LANES*AW-1:0]     op_rd_o,
  output logic [LANES*XLEN-1:0]   op_rs1_val_o,
  output logic [LANES*XLEN-1:0]   op_rs2_val_o,
  output logic [LANES*XLEN-1:0]   op_rs3_val_o,
  output logic [LANES*XLEN-1:0]   op_rd_val_o,
  output logic [LANES*CTRL_W-1:0] op_ctrl_o,
  output logic [LANES*SID_W-1:0]  op_sid_o,
  input  logic [LANES-1:0]        wb_valid_i,
  input  logic [LANES*AW-1:0]     wb_rd_i,
  input  logic [LANES*XLEN-1:0]   wb_data_i
);

  localparam int unsigned NENT = 1 << AW;
  localparam int unsigned NSRC = 4;  // 0:rs1 1:rs2 2:rs3 3:rd

`ifdef OPERANDS_RS3_EN
  localparam bit RS3_EN = 1'b1;
`else
  localparam bit RS3_EN = 1'b0;
`endif

  logic [XLEN-1:0] rf      [NENT];
  logic            addr_ok [NENT];

  // x0 and out-of-range entries read as constant zero and reject writes
  for (genvar r = 0; r < NENT; r++) begin : g_rf
    if (r == 0 || r >= NREG) begin : g_zero
      assign rf[r]      = '0;
      assign addr_ok[r] = 1'b0;
    end else begin : g_ent
      logic [XLEN-1:0] q;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q <= '0;
        end else begin
          for (int unsigned j = 0; j < LANES; j++)
            if (wb_valid_i[j] && wb_rd_i[j*AW +: AW] == AW'(r))
              q <= wb_data_i[j*XLEN +: XLEN];
        end
      end
      assign rf[r]      = q;
      assign addr_ok[r] = 1'b1;
    end
  end

  logic [AW-1:0]     dec_addr [LANES][NSRC];
  logic [XLEN-1:0]   ld_val   [LANES][NSRC];
  logic [XLEN-1:0]   rf_val   [LANES][NSRC];
  logic              rf_hit   [LANES][NSRC];
  logic [AW-1:0]     op_addr  [LANES][NSRC];
  logic [XLEN-1:0]   op_val   [LANES][NSRC];
  logic [LANES-1:0]  op_valid, op_v1, op_v2, op_v3;
  logic [CTRL_W-1:0] op_ctrl  [LANES];
  logic [SID_W-1:0]  op_sid   [LANES];

  // Later write-back ports override earlier ones, matching the array write order
  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) begin
      dec_addr[k][0] = dec_rs1_i[k*AW +: AW];
      dec_addr[k][1] = dec_rs2_i[k*AW +: AW];
      dec_addr[k][2] = dec_rs3_i[k*AW +: AW] & {AW{RS3_EN}};
      dec_addr[k][3] = dec_rd_i[k*AW +: AW];
      for (int unsigned s = 0; s < NSRC; s++) begin
        ld_val[k][s] = rf[dec_addr[k][s]];
        rf_hit[k][s] = 1'b0;
        rf_val[k][s] = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
          if (wb_valid_i[j] && wb_rd_i[j*AW +: AW] == dec_addr[k][s])
            ld_val[k][s] = wb_data_i[j*XLEN +: XLEN];
          if (wb_valid_i[j] && wb_rd_i[j*AW +: AW] == op_addr[k][s]) begin
            rf_hit[k][s] = 1'b1;
            rf_val[k][s] = wb_data_i[j*XLEN +: XLEN];
          end
        end
        if (!addr_ok[dec_addr[k][s]]) ld_val[k][s] = '0;
        if (!addr_ok[op_addr[k][s]])  rf_hit[k][s] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_valid <= '0;
      op_v1    <= '0;
      op_v2    <= '0;
      op_v3    <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        op_ctrl[k] <= '0;
        op_sid[k]  <= '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
          op_addr[k][s] <= '0;
          op_val[k][s]  <= '0;
        end
      end
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (flush_i[k]) begin
          op_valid[k] <= 1'b0;
        end else if (!stall_i[k]) begin
          op_valid[k] <= dec_valid_i[k];
          op_v1[k]    <= dec_rs1_valid_i[k];
          op_v2[k]    <= dec_rs2_valid_i[k];
          op_v3[k]    <= dec_rs3_valid_i[k] & RS3_EN;
          op_ctrl[k]  <= dec_ctrl_i[k*CTRL_W +: CTRL_W];
          op_sid[k]   <= dec_sid_i[k*SID_W +: SID_W];
          for (int unsigned s = 0; s < NSRC; s++) begin
            op_addr[k][s] <= dec_addr[k][s];
            op_val[k][s]  <= ld_val[k][s];
          end
        end else begin
          for (int unsigned s = 0; s < NSRC; s++)
            if (rf_hit[k][s]) op_val[k][s] <= rf_val[k][s];
        end
      end
    end
  end

  always_comb begin
    op_valid_o     = op_valid;
    op_rs1_valid_o = op_v1;
    op_rs2_valid_o = op_v2;
    op_rs3_valid_o = op_v3;
    op_rs1_o       = '0;
    op_rs2_o       = '0;
    op_rs3_o       = '0;
    op_rd_o        = '0;
    op_rs1_val_o   = '0;
    op_rs2_val_o   = '0;
    op_rs3_val_o   = '0;
    op_rd_val_o    = '0;
    op_ctrl_o      = '0;
    op_sid_o       = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      op_rs1_o[k*AW +: AW]       = op_addr[k][0];
      op_rs2_o[k*AW +: AW]       = op_addr[k][1];
      op_rs3_o[k*AW +: AW]       = op_addr[k][2];
      op_rd_o[k*AW +: AW]        = op_addr[k][3];
      op_rs1_val_o[k*XLEN +: XLEN] = op_val[k][0];
      op_rs2_val_o[k*XLEN +: XLEN] = op_val[k][1];
      op_rs3_val_o[k*XLEN +: XLEN] = op_val[k][2];
      op_rd_val_o[k*XLEN +: XLEN]  = op_val[k][3];
      op_ctrl_o[k*CTRL_W +: CTRL_W] = op_ctrl[k];
      op_sid_o[k*SID_W +: SID_W]    = op_sid[k];
    end
  end

endmodule

// File: doc/operands_stage_n.md
Name: operands_stage_n

Overview:
- Parametrised operand-fetch stage between decode and execute.
- Issue width (LANES), data width, register count and passthrough control width are all parameters.
- Per lane: registers decoded control, reads an internal register file into registered source values, and forwards same-cycle write-back data.
- While a lane is stalled, its held operand values are refreshed from write-back.

Parameters:
- LANES, 2, number of issue lanes; also the number of write-back ports.
- XLEN, 64, register data width.
- NREG, 32, architectural register count; register 0 reads as zero.
- AW, 5, register address width; must satisfy 2^AW >= NREG.
- CTRL_W, 20, width of opaque per-lane control bundle (rd_type, exe unit, func fields, endsim, auipc).
- SID_W, 5, scoreboard id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- stall_i  in  LANES  per-lane hold.
- flush_i  in  LANES  per-lane kill.
- dec_valid_i  in  LANES  decoded instruction valid.
- dec_rs1_valid_i, dec_rs2_valid_i, dec_rs3_valid_i  in  LANES each  source used.
- dec_rs1_i, dec_rs2_i, dec_rs3_i, dec_rd_i  in  LANES*AW each  register addresses.
- dec_ctrl_i  in  LANES*CTRL_W  passthrough control.
- dec_sid_i  in  LANES*SID_W  scoreboard id.
- op_valid_o  out  LANES  registered valid to execute.
- op_rs1_valid_o, op_rs2_valid_o, op_rs3_valid_o  out  LANES each.
- op_rs1_o, op_rs2_o, op_rs3_o, op_rd_o  out  LANES*AW each.
- op_rs1_val_o, op_rs2_val_o, op_rs3_val_o, op_rd_val_o  out  LANES*XLEN each  registered operand values.
- op_ctrl_o  out  LANES*CTRL_W.
- op_sid_o  out  LANES*SID_W.
- wb_valid_i  in  LANES  write enable per write-back port.
- wb_rd_i  in  LANES*AW  write address.
- wb_data_i  in  LANES*XLEN  write data.

Behaviour:
- Lane k occupies slice [k*W +: W] of every vector port.
- Reset (rst_n=0 at posedge): op_valid_o=0, all other outputs and all NREG register-file entries = 0. Reset mid-stall discards the held instruction.
- Per-lane priority at posedge: reset > flush_i[k] > !stall_i[k] > stall refresh.
- Flush: op_valid_o[k]<=0; other lane fields unchanged.
- Load (!stall_i[k]): all op_* fields <= dec_* fields. Values <= resolved read of dec address. Latency is 1 cycle decode->execute.
- Stall: fields hold. Refresh rule: for each held source s (rs1/rs2/rs3/rd), if some wb_valid_i[j] with wb_rd_i[j]==op_s and op_s!=0, then op_s_val <= that wb_data. Refresh applies whether or not op_valid_o[k]=1.
- Resolved read of address a:
  - a==0 -> 0.
  - Otherwise, if any wb port j has wb_valid_i[j] and wb_rd_i[j]==a, return wb_data_i[j] (bypass).
  - Otherwise return the array entry.
- Multiple write-back ports to the same address in one cycle: the highest index j wins, for both the array write and the bypass.
- Writes to address 0, and to addresses >= NREG, are ignored; reads of addresses >= NREG return 0.
- Read and write addresses are independent of stall/flush; write-back is always accepted.

Optional Feature:
- Macro OPERANDS_RS3_EN.
- Defined: rs3 fetch, bypass and refresh operate as specified.
- Undefined: rs3 ports remain present; dec_rs3_* inputs are ignored; op_rs3_valid_o, op_rs3_o and op_rs3_val_o are constant 0. This saves one read port per lane.

Test Plan:
- Reset then write x5=0xAA via wb0; next cycle decode lane0 rs1=5 valid -> after 1 clk op_valid_o[0]=1, op_rs1_val_o lane0=0xAA.
- Same-cycle bypass: decode lane1 rs2=7 while wb1 writes x7=0x1234 (array holds 0) -> op_rs2_val_o lane1=0x1234 next cycle.
- Collision: wb0 and wb1 both write x3 (0x11, 0x22) same cycle -> array x3=0x22; concurrent decode rs1=3 captures 0x22.
- Stall refresh: lane0 holds rs1=9 value 0 under stall_i[0]=1; wb writes x9=0x55 -> op_rs1_val_o lane0=0x55 next cycle, op_valid_o unchanged.
- Flush beats stall: flush_i[1]=stall_i[1]=1 -> op_valid_o[1]=0 next cycle. Write x0=0xFF then read rs1=0 -> 0.
- Assert rst_n=0 for one cycle while lane valid and stalled -> op_valid_o=0 and reading any previously written register returns 0. With OPERANDS_RS3_EN undefined, rs3=5 valid -> op_rs3_* all 0.
